// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the 16-bit J1 peripheral I/O bus between the J1 CPU
// (master 0) and a second bus master (master 1, e.g. DMA or loader).
//
// Round-robin arbitration with a registered grant. The granted master's address,
// strobes and write data are gated onto the shared bus. The high address byte is
// decoded into chip-selects, and read data is returned to the granted master only.
//
// Ports:
//   sys_clk_i, sys_rst_i     clock (rising edge), async active-high reset
//   mX_req/addr/rd/wr/dout   master X request, address, strobes, write data
//   mX_gnt                   master X grant (decoded from the state register)
//   mX_din                   read data to master X (zero when not granted)
//   bus_addr/rd/wr/dout      shared bus toward the peripherals
//   cs                       chip-selects: [0]=config 8'h67, [1]=uart 8'h69, [2]=dp_ram 8'h70
//   config_dout, uart_dout, dp_ram_dout  peripheral read data
//
// Optional feature macro: IOARB_HOLD_LIMIT_EN
//   When defined, a master that has held the bus for MAX_HOLD cycles is handed
//   over to a waiting master at the first cycle with no strobe active.
module io_bus_arbiter #(
  parameter int unsigned MAX_HOLD     = 16,
  parameter logic [15:0] DEFAULT_DATA = 16'h0666
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic        m0_rd,
  input  logic        m0_wr,
  input  logic [15:0] m0_dout,
  output logic        m0_gnt,
  output logic [15:0] m0_din,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic        m1_rd,
  input  logic        m1_wr,
  input  logic [15:0] m1_dout,
  output logic        m1_gnt,
  output logic [15:0] m1_din,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [15:0] bus_dout,
  output logic [2:0]  cs,
  input  logic [15:0] config_dout,
  input  logic        uart_dout,
  input  logic [15:0] dp_ram_dout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [15:0]      rdata;

`ifdef IOARB_HOLD_LIMIT_EN
  logic limit_hit;
  assign limit_hit = (hold_cnt == HOLD_LAST);
`endif

  // State, round-robin pointer and hold counter registers
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      hold_cnt   <= hold_cnt_nxt;
    end
  end

  // Arbitration: next state, round-robin pointer, hold counter
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    hold_cnt_nxt   = hold_cnt;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last_grant ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        // Dropping req releases the bus; a waiting master takes it with no bubble
        if (!m0_req) state_nxt = m1_req ? OWN1 : IDLE;
`ifdef IOARB_HOLD_LIMIT_EN
        else if (limit_hit && m1_req && !m0_rd && !m0_wr) state_nxt = OWN1;
`endif
      end
      OWN1: begin
        if (!m1_req) state_nxt = m0_req ? OWN0 : IDLE;
`ifdef IOARB_HOLD_LIMIT_EN
        else if (limit_hit && m0_req && !m1_rd && !m1_wr) state_nxt = OWN0;
`endif
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) begin
      hold_cnt_nxt = '0;
      if (state_nxt == OWN0) last_grant_nxt = 1'b0;
      if (state_nxt == OWN1) last_grant_nxt = 1'b1;
    end else if (state != IDLE && hold_cnt != HOLD_LAST) begin
      hold_cnt_nxt = hold_cnt + CNT_W'(1);
    end
  end

  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);

  // Bus mux, address decode and read-data return
  always_comb begin
    bus_addr = '0;
    bus_dout = '0;
    bus_rd   = 1'b0;
    bus_wr   = 1'b0;
    cs       = 3'b000;
    rdata    = DEFAULT_DATA;
    m0_din   = '0;
    m1_din   = '0;
    if (m0_gnt) begin
      bus_addr = m0_addr;
      bus_dout = m0_dout;
      bus_rd   = m0_rd;
      bus_wr   = m0_wr;
    end else if (m1_gnt) begin
      bus_addr = m1_addr;
      bus_dout = m1_dout;
      bus_rd   = m1_rd;
      bus_wr   = m1_wr;
    end
    if (m0_gnt || m1_gnt) begin
      unique case (bus_addr[15:8])
        8'h67:   cs = 3'b001;
        8'h69:   cs = 3'b010;
        8'h70:   cs = 3'b100;
        default: cs = 3'b000;
      endcase
    end
    unique case (cs)
      3'b001:  rdata = config_dout;
      3'b010:  rdata = {15'b0, uart_dout};
      3'b100:  rdata = dp_ram_dout;
      default: rdata = DEFAULT_DATA;
    endcase
    if (m0_gnt) m0_din = rdata;
    if (m1_gnt) m1_din = rdata;
  end

endmodule
